// File: rtl/inst_fetch_queue.sv
// IF->ID instruction buffer: valid/ready circular FIFO of {pc, inst, imm_type}, predecoded on push.
// Define IFQ_BYPASS_EN to let an instruction pass straight through an empty queue in the same cycle.
module inst_fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_inst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic [2:0]  out_imm_type
);

  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [2:0] NOTYPE = 3'd0;
  localparam logic [2:0] RTYPE  = 3'd1;
  localparam logic [2:0] ITYPE  = 3'd2;
  localparam logic [2:0] STYPE  = 3'd3;
  localparam logic [2:0] BTYPE  = 3'd4;
  localparam logic [2:0] UTYPE  = 3'd5;
  localparam logic [2:0] JTYPE  = 3'd6;

  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      inst_mem [DEPTH];
  logic [2:0]       type_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [2:0]       in_imm_type;
  logic             empty;
  logic             bypass;
  logic             push;
  logic             pop;

  // Opcode -> immediate-format predecode.
  always_comb begin
    in_imm_type = NOTYPE;
    case (in_inst[6:0])
      7'b0110011:                         in_imm_type = RTYPE;
      7'b0010011, 7'b0000011, 7'b1100111: in_imm_type = ITYPE;
      7'b0100011:                         in_imm_type = STYPE;
      7'b1100011:                         in_imm_type = BTYPE;
      7'b0110111, 7'b0010111:             in_imm_type = UTYPE;
      7'b1101111:                         in_imm_type = JTYPE;
      default:                            in_imm_type = NOTYPE;
    endcase
  end

  assign empty    = (count == '0);
  assign in_ready = (count != FULL_CNT) & ~flush;

`ifdef IFQ_BYPASS_EN
  assign bypass = empty & in_valid & ~flush;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid = ~empty | bypass;
  // Storage pop only; a bypassed instruction never touches the buffer.
  assign pop  = ~empty & out_ready;
  assign push = in_valid & in_ready & ~(bypass & out_ready);

  // Head selection: buffered entry, bypassed input, or NOP bubble.
  always_comb begin
    out_pc       = 32'h0;
    out_inst     = NOP_INST;
    out_imm_type = ITYPE;
    if (!empty) begin
      out_pc       = pc_mem[rd_ptr];
      out_inst     = inst_mem[rd_ptr];
      out_imm_type = type_mem[rd_ptr];
    end else if (bypass) begin
      out_pc       = in_pc;
      out_inst     = in_inst;
      out_imm_type = in_imm_type;
    end
  end

  // Pointer and occupancy control; reset beats flush, both clear everything.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; contents are meaningless while empty.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      pc_mem[wr_ptr]   <= in_pc;
      inst_mem[wr_ptr] <= in_inst;
      type_mem[wr_ptr] <= in_imm_type;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed scenarios plus random traffic vs a queue model.
module tb_inst_fetch_queue;

  localparam int unsigned DEPTH = 4;

  localparam logic [2:0] T_NO = 3'd0;
  localparam logic [2:0] T_R  = 3'd1;
  localparam logic [2:0] T_I  = 3'd2;
  localparam logic [2:0] T_S  = 3'd3;
  localparam logic [2:0] T_B  = 3'd4;
  localparam logic [2:0] T_U  = 3'd5;
  localparam logic [2:0] T_J  = 3'd6;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0]  out_imm_type;

  int   checks = 0;
  int   errors = 0;
  ent_t q[$];
  bit   last_push;

  inst_fetch_queue #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_imm_type(out_imm_type)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] ref_type(input logic [31:0] inst);
    case (inst[6:0])
      7'h33:               return T_R;
      7'h13, 7'h03, 7'h67: return T_I;
      7'h23:               return T_S;
      7'h63:               return T_B;
      7'h37, 7'h17:        return T_U;
      7'h6f:               return T_J;
      default:             return T_NO;
    endcase
  endfunction

  // One clock: drive at negedge, check shortly after, then advance the model.
  task automatic step(input logic r, input logic f, input logic iv, input logic [31:0] pc,
                      input logic [31:0] inst, input logic ordy, input bit do_chk);
    bit          byp;
    bit          ev;
    bit          er;
    logic [31:0] epc;
    logic [31:0] einst;
    logic [2:0]  etype;
    @(negedge clk);
    rst = r; flush = f; in_valid = iv; in_pc = pc; in_inst = inst; out_ready = ordy;
    #1;
    byp = 1'b0;
`ifdef IFQ_BYPASS_EN
    byp = (q.size() == 0) && iv && !f;
`endif
    ev = (q.size() != 0) || byp;
    er = (q.size() < DEPTH) && !f;
    if (q.size() != 0) begin
      epc = q[0].pc; einst = q[0].inst; etype = ref_type(q[0].inst);
    end else if (byp) begin
      epc = pc; einst = inst; etype = ref_type(inst);
    end else begin
      epc = 32'h0; einst = 32'h13; etype = T_I;
    end
    if (do_chk) begin
      check("in_ready", 32'(in_ready), 32'(er));
      check("out_valid", 32'(out_valid), 32'(ev));
      check("out_pc", out_pc, epc);
      check("out_inst", out_inst, einst);
      check("out_imm_type", 32'(out_imm_type), 32'(etype));
    end
    last_push = 1'b0;
    if (r || f) begin
      q.delete();
    end else if (!(byp && ordy)) begin
      if (q.size() != 0 && ordy) void'(q.pop_front());
      if (iv && er) begin
        q.push_back('{pc: pc, inst: inst});
        last_push = 1'b1;
      end
    end else begin
      last_push = 1'b1;
    end
  endtask

  logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h7f};

  initial begin
    int idx;
    int cyc;
    logic [31:0] ri;
    logic [31:0] seq_inst [4] = '{32'h00112023, 32'h00208463, 32'h000122B7, 32'h008000EF};

    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1);
    check("reset_empty", 32'(q.size()), 32'd0);

    // addi push, drain
    step(0, 0, 1, 32'h0, 32'h00500093, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 1, 1);

    // fill with S/B/U/J under stall, then one cycle of push+pop attempt while full
    for (int i = 0; i < 4; i++) step(0, 0, 1, 32'(i * 4), seq_inst[i], 0, 1);
    step(0, 0, 1, 32'h100, 32'h00000013, 1, 1);
    check("full_popped_no_push", 32'(q.size()), 32'd3);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1, 1);

    // sequential PCs across wrap with toggling out_ready
    idx = 0;
    cyc = 0;
    while (idx < 10 && cyc < 100) begin
      step(0, 0, 1, 32'(idx * 4), 32'h00000013 | 32'(idx << 7), 1'(cyc % 2), 1);
      if (last_push) idx++;
      cyc++;
    end
    check("seq_all_pushed", 32'(idx), 32'd10);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 1, 1);

    // flush with 3 entries plus simultaneous push/pop
    for (int i = 0; i < 3; i++) step(0, 0, 1, 32'(32'h200 + i * 4), 32'h00000033, 0, 1);
    step(0, 1, 1, 32'h300, 32'h00000033, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // reset mid-stream with 2 entries
    for (int i = 0; i < 2; i++) step(0, 0, 1, 32'(32'h400 + i * 4), 32'h0000006f, 0, 1);
    step(1, 0, 1, 32'h500, 32'h00000013, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1);

    // empty queue with valid input and ready output (bypass case when enabled)
    step(0, 0, 1, 32'h600, 32'h00100093, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      ri = $urandom;
      ri[6:0] = ops[$urandom_range(9)];
      step(1'($urandom_range(63) == 0), 1'($urandom_range(15) == 0),
           1'($urandom_range(9) < 7), $urandom, ri, 1'($urandom_range(9) < 6), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
